bram_arbiter: RTL and testbench
===============================

# bram_arbiter

- Shares one single-port 8-bit BRAM (write-enable, one-cycle registered read) between two requesters.
  - Port A: CPU bus side, high priority.
  - Port B: secondary master (video fetch / ROM loader), low priority.
- Sequences every access through a fixed FSM with a req/ack handshake.
- Guarantees port B forward progress with a starvation counter.
- Sits directly in front of the memory, owning all of its enable, write, address and data inputs.

## Interface
- AW, 16, memory address width.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which B wins; 0 makes B win whenever it requests; range 0..15.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- a_req, b_req  in  1  access request; level, held until ack.
- a_we, b_we  in  1  1 = write, 0 = read; stable while req high.
- a_addr, b_addr  in  AW  address; stable while req high.
- a_wdata, b_wdata  in  8  write data; stable while req high.
- a_ack, b_ack  out  1  one-cycle completion pulse.
- a_rdata, b_rdata  out  8  registered read data; valid from ack, held until that port's next read ack.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_din  out  8  memory write data.
- mem_dout  in  8  memory read data; valid the cycle after an enabled read.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, RDWAIT, DONE.
- IDLE, no request pending: stay in IDLE.
- IDLE, a request pending:
  - Pick the winner.
  - Register winner's we/addr/wdata into mem_we/mem_addr/mem_din and set mem_en.
  - Record winner id; go to ACCESS.
- Winner selection:
  - B wins if b_req and (not a_req, or starve_cnt >= STARVE_LIMIT).
  - Otherwise A wins.
- starve_cnt, 4 bits, updated only on IDLE-to-ACCESS transitions:
  - +1 when A wins while b_req is high; saturates at 15.
  - Cleared when B wins.
- ACCESS (mem_en = 1 for exactly this cycle):
  - Write: winner's ack = 1 this cycle; next state IDLE.
  - Read: next state RDWAIT.
- RDWAIT:
  - mem_dout is valid; capture it into the winner's rdata at the end of the cycle.
  - Winner's ack registered high; next state DONE.
- DONE: winner's ack = 1; next state IDLE.
- Outside ACCESS: mem_en = 0 and mem_we = 0; mem_addr/mem_din hold their last values.
- Requesters drop req on the edge that ends their ack cycle. Because ack is always followed by IDLE, the arbiter never re-grants a stale request.
- A req deasserted before its ack is a protocol violation. If it happens, the access still completes and ack still pulses.
- The non-winning port's ack and rdata are untouched.

## Timing
- Reset values:
  - State IDLE, starve_cnt 0, busy 0.
  - a_ack, b_ack, mem_en, mem_we all 0.
  - mem_addr, mem_din, a_rdata, b_rdata all 0.
- Reset in any state abandons the access: no ack, no rdata update, mem_en = 0 on the following cycle.
- Write latency: req sampled at IDLE cycle t → mem_en and ack at t+1 → IDLE at t+2.
- Read latency: req sampled at t → mem_en at t+1 → mem_dout valid at t+2 → ack + rdata at t+3 → IDLE at t+4.
- Throughput: one write per 2 cycles; one read per 4 cycles.
- Simultaneous a_req and b_req in IDLE: resolved by the selection rule only; the losing request stays pending with no side effect.
- A request arriving in a non-IDLE state waits; it is considered at the next IDLE.
- At most one ack is high per cycle; a_ack and b_ack are never both high.

## Structure
- Shared include file:
  - State encodings (2 bits): IDLE=0, ACCESS=1, RDWAIT=2, DONE=3.
  - Port-id constants: PORT_A=0, PORT_B=1.
  - STARVE_LIMIT default.
- Single module, no sub-modules. Contents: FSM, winner register, starvation counter, output registers.
- Instantiated beside the existing BRAM, wired mem_* ↔ ena/wea/addra/dina/douta, with clk driving the memory clock.

## Test plan
- Single A write: A write 0x0012 ← 0x5A. Expect mem_en and a_ack high one cycle later. A later A read of 0x0012 acks 3 cycles after sampling with a_rdata = 0x5A.
- Contention: a_req and b_req both held continuously, STARVE_LIMIT = 4. Expect grant order A,A,A,A,B repeating; starve_cnt returns to 0 after each B grant.
- STARVE_LIMIT = 0: both requesting. Expect B wins every arbitration while b_req is high; A served only when b_req is low.
- Rdata hold: B reads 0x00A5 (0x38), then A writes 0x00A5 ← 0x11. Expect b_rdata stays 0x38 until B's next read ack.
- Reset in RDWAIT during an A read: assert reset one cycle. Expect no a_ack; a_rdata keeps its prior value; state IDLE; mem_en 0; next request serviced normally.
- Back-to-back B writes: B re-asserts req immediately after each ack. Expect exactly one ack per request, one access every 2 cycles, no duplicate memory writes.

Source files
------------

// File: rtl/bram_arbiter_pkg.sv
// bram_arbiter_pkg: shared FSM encodings, port ids and defaults for bram_arbiter
package bram_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } state_t;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-port req/ack arbiter in front of a single-port 8-bit BRAM
// with A priority and a starvation counter guaranteeing B progress.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int unsigned AW           = 16,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_wdata,
    output logic          a_ack,
    output logic [7:0]    a_rdata,
    output logic          b_ack,
    output logic [7:0]    b_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    output logic          busy
);
    state_t        state_q, state_d;
    logic          win_q, win_d;
    logic [3:0]    starve_q, starve_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [7:0]    a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic          grant, b_win, win_we, rd_a, rd_b;

    always_comb begin
        grant      = state_q == IDLE && (a_req || b_req);
        b_win      = b_req && (!a_req || starve_q >= 4'(STARVE_LIMIT));
        win_we     = b_win ? b_we : a_we;
        rd_a       = state_q == RDWAIT && win_q == PORT_A;
        rd_b       = state_q == RDWAIT && win_q == PORT_B;
        state_d    = state_q == IDLE   ? (grant ? ACCESS : IDLE) :
                     state_q == ACCESS ? (mem_we_q ? IDLE : RDWAIT) :
                     state_q == RDWAIT ? DONE : IDLE;
        win_d      = grant ? b_win : win_q;
        // Counter only moves when an arbitration actually happens.
        starve_d   = !grant ? starve_q :
                     b_win ? 4'd0 :
                     (b_req && starve_q != 4'hF) ? starve_q + 4'd1 : starve_q;
        mem_en_d   = grant;
        mem_we_d   = grant && win_we;
        mem_addr_d = grant ? (b_win ? b_addr : a_addr) : mem_addr_q;
        mem_din_d  = grant ? (b_win ? b_wdata : a_wdata) : mem_din_q;
        // Writes ack during ACCESS; reads ack in DONE once rdata is captured.
        a_ack_d    = (grant && !b_win && a_we) || rd_a;
        b_ack_d    = (grant && b_win && b_we) || rd_b;
        a_rdata_d  = rd_a ? mem_dout : a_rdata_q;
        b_rdata_d  = rd_b ? mem_dout : b_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            win_q      <= PORT_A;
            starve_q   <= 4'd0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= 8'h00;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= 8'h00;
            b_rdata_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            starve_q   <= starve_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign mem_en   = mem_en_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed scenario tests for bram_arbiter against a BRAM model
module tb_bram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [15:0] a_addr = '0, b_addr = '0;
    logic [7:0]  a_wdata = '0, b_wdata = '0;
    logic        a_ack, b_ack, mem_en, mem_we, busy;
    logic [7:0]  a_rdata, b_rdata, mem_din;
    logic [7:0]  mem_dout = 8'h00;
    logic [15:0] mem_addr;
    logic        z_a_req = 1'b0, z_b_req = 1'b0;
    logic        z_a_ack, z_b_ack, z_mem_en, z_mem_we, z_busy;
    logic [7:0]  z_a_rdata, z_b_rdata, z_mem_din;
    logic [15:0] z_mem_addr;
    logic [7:0]  z_mem_dout = 8'h00;
    logic [7:0]  mem [0:65535];
    int          wr_cnt = 0;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    bram_arbiter #(.AW(16), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    bram_arbiter #(.AW(16), .STARVE_LIMIT(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .a_req(z_a_req), .a_we(1'b1), .a_addr(16'h0001), .a_wdata(8'hAA),
        .b_req(z_b_req), .b_we(1'b1), .b_addr(16'h0002), .b_wdata(8'hBB),
        .a_ack(z_a_ack), .a_rdata(z_a_rdata), .b_ack(z_b_ack), .b_rdata(z_b_rdata),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_din(z_mem_din),
        .mem_dout(z_mem_dout), .busy(z_busy)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_din;
                wr_cnt <= wr_cnt + 1;
            end
            mem_dout <= mem[mem_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        total++;
        if ({busy, a_ack, b_ack, mem_en, mem_we} !== 5'b0)
            $display("FAIL reset_ctrl got %b exp 00000", {busy, a_ack, b_ack, mem_en, mem_we});
        else passed++;
        total++;
        if ({mem_addr, mem_din, a_rdata, b_rdata} !== 40'h0)
            $display("FAIL reset_data got %h exp 0", {mem_addr, mem_din, a_rdata, b_rdata});
        else passed++;
    endtask

    task automatic test_reset_rdwait;
        int n;
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0040;
        tick;
        total++;
        if (mem_en !== 1'b1) $display("FAIL rst_rd_access mem_en got %b exp 1", mem_en);
        else passed++;
        tick;
        total++;
        if ({busy, a_ack} !== 2'b10) $display("FAIL rst_rd_rdwait busy/ack got %b exp 10", {busy, a_ack});
        else passed++;
        reset = 1'b1; a_req = 1'b0;
        tick;
        total++;
        if ({a_ack, busy, mem_en} !== 3'b0 || a_rdata !== 8'h00)
            $display("FAIL rst_rd_abandon ack/busy/en got %b rdata %h exp 000 rdata 00", {a_ack, busy, mem_en}, a_rdata);
        else passed++;
        reset = 1'b0;
        tick;
        total++;
        if ({a_ack, mem_en, busy} !== 3'b0) $display("FAIL rst_rd_after got %b exp 000", {a_ack, mem_en, busy});
        else passed++;
        a_req = 1'b1;
        n = 0;
        do begin tick; n++; end while (!a_ack && n < 10);
        total++;
        if (n !== 3 || a_rdata !== 8'h77)
            $display("FAIL rst_rd_retry latency %0d rdata %h exp 3 77", n, a_rdata);
        else passed++;
        a_req = 1'b0;
        tick;
    endtask

    task automatic test_single_write;
        int n;
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0012; a_wdata = 8'h5A;
        tick;
        total++;
        if ({mem_en, mem_we, a_ack, b_ack} !== 4'b1110 || mem_addr !== 16'h0012 || mem_din !== 8'h5A)
            $display("FAIL wr_access en/we/aack/back %b addr %h din %h exp 1110 0012 5a", {mem_en, mem_we, a_ack, b_ack}, mem_addr, mem_din);
        else passed++;
        a_req = 1'b0;
        tick;
        total++;
        if ({mem_en, mem_we, a_ack, busy} !== 4'b0 || mem[16'h0012] !== 8'h5A)
            $display("FAIL wr_done ctrl %b mem %h exp 0000 5a", {mem_en, mem_we, a_ack, busy}, mem[16'h0012]);
        else passed++;
        a_req = 1'b1; a_we = 1'b0;
        n = 0;
        do begin tick; n++; end while (!a_ack && n < 10);
        total++;
        if (n !== 3 || a_rdata !== 8'h5A)
            $display("FAIL rd_back latency %0d rdata %h exp 3 5a", n, a_rdata);
        else passed++;
        a_req = 1'b0;
        tick;
        total++;
        if ({busy, a_ack} !== 2'b0) $display("FAIL rd_idle got %b exp 00", {busy, a_ack});
        else passed++;
    endtask

    task automatic test_contention;
        int  n;
        byte got, exp;
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0200; a_wdata = 8'h01;
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0300; b_wdata = 8'h02;
        for (int k = 0; k < 10; k++) begin
            n = 0;
            do begin tick; n++; end while (!(a_ack || b_ack) && n < 6);
            got = (a_ack && b_ack) ? "X" : a_ack ? "A" : b_ack ? "B" : "T";
            exp = (k % 5 == 4) ? "B" : "A";
            total++;
            if (got !== exp) $display("FAIL contention_grant%0d got %c exp %c", k, got, exp);
            else passed++;
        end
        a_req = 1'b0; b_req = 1'b0;
        tick;
    endtask

    task automatic test_starve_zero;
        int  n;
        byte got;
        z_a_req = 1'b1; z_b_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) z_b_req = 1'b0;
            n = 0;
            do begin tick; n++; end while (!(z_a_ack || z_b_ack) && n < 6);
            got = (z_a_ack && z_b_ack) ? "X" : z_a_ack ? "A" : z_b_ack ? "B" : "T";
            total++;
            if (got !== ((k == 4) ? "A" : "B"))
                $display("FAIL starve0_grant%0d got %c exp %c", k, got, (k == 4) ? "A" : "B");
            else passed++;
        end
        z_a_req = 1'b0;
        tick;
    endtask

    task automatic test_rdata_hold;
        int n;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h00A5;
        n = 0;
        do begin tick; n++; end while (!b_ack && n < 10);
        total++;
        if (n !== 3 || b_rdata !== 8'h38 || a_ack !== 1'b0)
            $display("FAIL hold_bread latency %0d rdata %h aack %b exp 3 38 0", n, b_rdata, a_ack);
        else passed++;
        b_req = 1'b0;
        tick;
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h00A5; a_wdata = 8'h11;
        n = 0;
        do begin tick; n++; end while (!a_ack && n < 10);
        a_req = 1'b0;
        tick;
        total++;
        if (b_rdata !== 8'h38 || mem[16'h00A5] !== 8'h11)
            $display("FAIL hold_after_awrite b_rdata %h mem %h exp 38 11", b_rdata, mem[16'h00A5]);
        else passed++;
        b_req = 1'b1;
        n = 0;
        do begin
            tick; n++;
            total++;
            if (!b_ack && b_rdata !== 8'h38) $display("FAIL hold_early_update cyc %0d b_rdata %h exp 38", n, b_rdata);
            else passed++;
        end while (!b_ack && n < 10);
        total++;
        if (b_rdata !== 8'h11) $display("FAIL hold_reread b_rdata %h exp 11", b_rdata);
        else passed++;
        b_req = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        int n, w0;
        w0 = wr_cnt;
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0100; b_wdata = 8'hC0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin tick; n++; end while (!b_ack && n < 6);
            total++;
            if (n !== ((k == 0) ? 1 : 2) || mem_addr !== 16'h0100 + 16'(k))
                $display("FAIL b2b_ack%0d spacing %0d addr %h exp %0d %h", k, n, mem_addr, (k == 0) ? 1 : 2, 16'h0100 + 16'(k));
            else passed++;
            b_addr = 16'h0101 + 16'(k); b_wdata = 8'hC1 + 8'(k);
        end
        b_req = 1'b0;
        tick;
        tick;
        total++;
        if (wr_cnt - w0 !== 4 || b_ack !== 1'b0 || busy !== 1'b0)
            $display("FAIL b2b_writes count %0d back %b busy %b exp 4 0 0", wr_cnt - w0, b_ack, busy);
        else passed++;
        total++;
        if ({mem[16'h0100], mem[16'h0101], mem[16'h0102], mem[16'h0103]} !== 32'hC0C1C2C3)
            $display("FAIL b2b_data got %h exp c0c1c2c3", {mem[16'h0100], mem[16'h0101], mem[16'h0102], mem[16'h0103]});
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0040] = 8'h77;
        mem[16'h00A5] = 8'h38;
        test_reset;
        test_reset_rdwait;
        test_single_write;
        test_contention;
        test_starve_zero;
        test_rdata_hold;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
